// File: rtl/pipelined_adder.sv
// Carry-segmented pipelined adder/subtractor with valid/ready flow control.
// Each stage resolves one STAGE_BITS slice of the carry chain and forwards the rest.
module pipelined_adder #(
   parameter int BITWIDTH   = 32,
   parameter int STAGE_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITWIDTH-1:0] bits_a,
   input  logic [BITWIDTH-1:0] bits_b,
   input  logic                carry_in,
   input  logic                sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITWIDTH-1:0] sum,
   output logic                carry_out,
   output logic                overflow
);

   localparam int NUM_STAGES = (BITWIDTH + STAGE_BITS - 1) / STAGE_BITS;

   logic [BITWIDTH-1:0] b_eff;
   logic                c0;

   assign b_eff = sub ? ~bits_b : bits_b;
   assign c0    = carry_in ^ sub;

   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam int LO = gi * STAGE_BITS;
      localparam int HI = (LO + STAGE_BITS >= BITWIDTH) ? BITWIDTH - 1 : LO + STAGE_BITS - 1;
      localparam int W  = HI - LO + 1;
      localparam int UP = BITWIDTH - LO;

      // Operand bits still unresolved on entry, right-aligned so bit 0 is slice bit 0.
      logic [UP-1:0] a_in;
      logic [UP-1:0] b_in;
      logic          c_in;
      logic          v_in;
      logic          ready_nxt;
      logic          stage_ready;
      logic          load;
      logic [W:0]    slice_sum;
      logic [HI:0]   sum_next;
      logic          v_reg;
      logic          carry_reg;
      logic [HI:0]   sum_reg;

      if (gi == 0) begin : g_head
         assign a_in     = bits_a;
         assign b_in     = b_eff;
         assign c_in     = c0;
         assign v_in     = in_valid;
         assign sum_next = slice_sum[W-1:0];
      end else begin : g_tail
         assign a_in     = g_stage[gi-1].g_mid.a_rem_reg;
         assign b_in     = g_stage[gi-1].g_mid.b_rem_reg;
         assign c_in     = g_stage[gi-1].carry_reg;
         assign v_in     = g_stage[gi-1].v_reg;
         assign sum_next = {slice_sum[W-1:0], g_stage[gi-1].sum_reg};
      end

      assign stage_ready = !v_reg || ready_nxt;
      assign load        = stage_ready && v_in;
      assign slice_sum   = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_reg     <= 1'b0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
         end else begin
            if (stage_ready) begin
               v_reg <= v_in;
            end
            if (load) begin
               carry_reg <= slice_sum[W];
               sum_reg   <= sum_next;
            end
         end
      end

      if (gi < NUM_STAGES - 1) begin : g_mid
         logic [BITWIDTH-HI-2:0] a_rem_reg;
         logic [BITWIDTH-HI-2:0] b_rem_reg;

         assign ready_nxt = g_stage[gi+1].stage_ready;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_rem_reg <= '0;
               b_rem_reg <= '0;
            end else if (load) begin
               a_rem_reg <= a_in[UP-1:W];
               b_rem_reg <= b_in[UP-1:W];
            end
         end
      end else begin : g_last
         logic ovf_reg;

         assign ready_nxt = out_ready;

         // Top slice holds the true MSBs of A and B', so signed overflow is decided here.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_reg <= 1'b0;
            end else if (load) begin
               ovf_reg <= (a_in[W-1] == b_in[W-1]) && (slice_sum[W-1] != a_in[W-1]);
            end
         end
      end
   end

   assign in_ready  = g_stage[0].stage_ready;
   assign out_valid = g_stage[NUM_STAGES-1].v_reg;
   assign sum       = g_stage[NUM_STAGES-1].sum_reg;
   assign carry_out = g_stage[NUM_STAGES-1].carry_reg;
   assign overflow  = g_stage[NUM_STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on 8/4 and 32/8 builds, randomized
// streams with backpressure on 13/4, 32/8 and 8/8 builds against an arithmetic model.
module tb_pipelined_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        cin;
   logic        sub_op;
   logic [31:0] a;
   logic [31:0] b;
   int          sel;
   int          checks = 0;
   int          errors = 0;

   logic [3:0]  iv;
   logic [3:0]  o_ready;
   logic [3:0]  o_valid;
   logic [3:0]  o_cout;
   logic [3:0]  o_ovf;
   logic [31:0] o_sum [4];
   logic [7:0]  sum_0;
   logic [12:0] sum_1;
   logic [31:0] sum_2;
   logic [7:0]  sum_3;

   always #5 clk = ~clk;

   assign iv       = in_valid ? 4'(1 << sel) : 4'd0;
   assign o_sum[0] = {24'd0, sum_0};
   assign o_sum[1] = {19'd0, sum_1};
   assign o_sum[2] = sum_2;
   assign o_sum[3] = {24'd0, sum_3};

   pipelined_adder #(.BITWIDTH(8), .STAGE_BITS(4)) dut_8_4 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(o_ready[0]),
      .bits_a(a[7:0]), .bits_b(b[7:0]), .carry_in(cin), .sub(sub_op),
      .out_valid(o_valid[0]), .out_ready(out_ready), .sum(sum_0),
      .carry_out(o_cout[0]), .overflow(o_ovf[0]));

   pipelined_adder #(.BITWIDTH(13), .STAGE_BITS(4)) dut_13_4 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(o_ready[1]),
      .bits_a(a[12:0]), .bits_b(b[12:0]), .carry_in(cin), .sub(sub_op),
      .out_valid(o_valid[1]), .out_ready(out_ready), .sum(sum_1),
      .carry_out(o_cout[1]), .overflow(o_ovf[1]));

   pipelined_adder #(.BITWIDTH(32), .STAGE_BITS(8)) dut_32_8 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(o_ready[2]),
      .bits_a(a), .bits_b(b), .carry_in(cin), .sub(sub_op),
      .out_valid(o_valid[2]), .out_ready(out_ready), .sum(sum_2),
      .carry_out(o_cout[2]), .overflow(o_ovf[2]));

   pipelined_adder #(.BITWIDTH(8), .STAGE_BITS(8)) dut_8_8 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(o_ready[3]),
      .bits_a(a[7:0]), .bits_b(b[7:0]), .carry_in(cin), .sub(sub_op),
      .out_valid(o_valid[3]), .out_ready(out_ready), .sum(sum_3),
      .carry_out(o_cout[3]), .overflow(o_ovf[3]));

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {overflow, carry_out, sum} from plain integer arithmetic on w-bit values.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic so, input int w);
      longint mask, xa, yb, c0, full, lim, sx, sy, total;
      logic   ovf, cout;
      mask  = (longint'(1) << w) - 1;
      xa    = longint'(x) & mask;
      yb    = longint'(so ? ~y : y) & mask;
      c0    = longint'(ci ^ so);
      full  = xa + yb + c0;
      cout  = ((full >> w) & 1) != 0;
      lim   = longint'(1) << (w - 1);
      sx    = (xa >= lim) ? xa - 2 * lim : xa;
      sy    = (yb >= lim) ? yb - 2 * lim : yb;
      total = sx + sy + c0;
      ovf   = (total >= lim) || (total < -lim);
      return {ovf, cout, 32'(full & mask)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input string tag, input int s, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic so, input logic [33:0] exp_res, input int exp_lat);
      int lat;
      sel = s; a = x; b = y; cin = ci; sub_op = so;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check_value({tag, "_in_ready"}, 64'(o_ready[s]), 64'd1);
      step();
      in_valid = 1'b0;
      a = $urandom; b = $urandom;
      lat = 1;
      @(negedge clk);
      while (!o_valid[s] && lat < 20) begin
         step();
         lat++;
         @(negedge clk);
      end
      check_value({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_value({tag, "_result"}, 64'({o_ovf[s], o_cout[s], o_sum[s]}), 64'(exp_res));
      $display("%s: a=0x%0h b=0x%0h cin=%0b sub=%0b -> sum=0x%0h cout=%0b ovf=%0b lat=%0d",
               tag, x, y, ci, so, o_sum[s], o_cout[s], o_ovf[s], lat);
      step();
   endtask

   task automatic run_random(input int s, input int w, input int n);
      logic [33:0] q[$];
      logic [33:0] got;
      logic [33:0] exp;
      logic [33:0] prev;
      logic        stalled;
      int          accepted;
      int          cycles;
      stalled = 1'b0; prev = '0; accepted = 0; cycles = 0;
      sel = s;
      while ((accepted < n || q.size() != 0) && cycles < 20000) begin
         in_valid  = (accepted < n) && ($urandom_range(0, 3) != 0);
         a         = $urandom;
         b         = $urandom;
         cin       = 1'($urandom_range(0, 1));
         sub_op    = 1'($urandom_range(0, 1));
         out_ready = (accepted >= n) || ($urandom_range(0, 3) != 0);
         @(negedge clk);
         got = {o_ovf[s], o_cout[s], o_sum[s]};
         if (stalled) check_value("rand_hold", 64'(got), 64'(prev));
         if (o_valid[s] && out_ready) begin
            if (q.size() == 0) begin
               check_value("rand_spurious", 64'(o_valid[s]), 64'd0);
            end else begin
               exp = q.pop_front();
               check_value("rand_result", 64'(got), 64'(exp));
               $display("rand w=%0d: sum=0x%0h cout=%0b ovf=%0b", w, got[31:0], got[32], got[33]);
            end
         end
         if (in_valid && o_ready[s]) begin
            q.push_back(model(a, b, cin, sub_op, w));
            accepted++;
         end
         stalled = o_valid[s] && !out_ready;
         prev    = got;
         step();
         cycles++;
      end
      in_valid = 1'b0;
      check_value("rand_drained", 64'(q.size()), 64'd0);
      check_value("rand_accepted", 64'(accepted), 64'(n));
   endtask

   initial begin
      logic [7:0]  ta [4];
      logic [7:0]  tbv [4];
      logic        tc [4];
      logic [33:0] t1_exp [4];
      logic [7:0]  bp_a [3];
      logic [7:0]  bp_b [3];
      logic [33:0] bp_exp [3];
      int          acc;

      ta  = '{8'h00, 8'hFF, 8'hAA, 8'hAA};
      tbv = '{8'h00, 8'h01, 8'h55, 8'h55};
      tc  = '{1'b1, 1'b0, 1'b0, 1'b1};
      t1_exp = '{{2'b00, 32'h01}, {2'b01, 32'h00}, {2'b00, 32'hFF}, {2'b01, 32'h00}};
      bp_a   = '{8'h11, 8'h40, 8'hF0};
      bp_b   = '{8'h22, 8'h40, 8'h20};
      bp_exp = '{{2'b00, 32'h33}, {2'b10, 32'h80}, {2'b01, 32'h10}};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub_op = 1'b0; sel = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check_value("reset_out_valid", 64'(o_valid[i]), 64'd0);
         check_value("reset_outputs", 64'({o_ovf[i], o_cout[i], o_sum[i]}), 64'd0);
         check_value("reset_in_ready", 64'(o_ready[i]), 64'd1);
      end
      step();

      // Back-to-back beats, results two cycles after each accept.
      sel = 0; out_ready = 1'b1; sub_op = 1'b0;
      for (int t = 0; t < 7; t++) begin
         if (t < 4) begin
            in_valid = 1'b1; a = 32'(ta[t]); b = 32'(tbv[t]); cin = tc[t];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         check_value("t1_out_valid", 64'(o_valid[0]), 64'(t >= 2 && t < 6));
         if (t >= 2 && t < 6) begin
            check_value("t1_result", 64'({o_ovf[0], o_cout[0], o_sum[0]}), 64'(t1_exp[t-2]));
            $display("t1 beat %0d: sum=0x%0h cout=%0b ovf=%0b", t - 2, o_sum[0], o_cout[0], o_ovf[0]);
         end
         step();
      end

      run_one("t2_7f_plus_1", 0, 32'h7F, 32'h01, 1'b0, 1'b0, {2'b10, 32'h80}, 2);
      run_one("t2_5_minus_7", 0, 32'h05, 32'h07, 1'b0, 1'b1, {2'b00, 32'hFE}, 2);
      run_one("t2_80_minus_1", 0, 32'h80, 32'h01, 1'b0, 1'b1, {2'b11, 32'h7F}, 2);
      run_one("t2_10_minus_1_borrow", 0, 32'h10, 32'h01, 1'b1, 1'b1, {2'b01, 32'h0E}, 2);

      // Backpressure: two beats fill the 8/4 pipe, the third waits at the input.
      sel = 0; cin = 1'b0; sub_op = 1'b0; acc = 0;
      for (int t = 0; t < 8; t++) begin
         if (acc < 3) begin
            in_valid = 1'b1; a = 32'(bp_a[acc]); b = 32'(bp_b[acc]);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = (t >= 5);
         @(negedge clk);
         check_value("t3_in_ready", 64'(o_ready[0]), 64'(t < 2 || t >= 5));
         if (t >= 2) begin
            check_value("t3_out_valid", 64'(o_valid[0]), 64'd1);
            check_value("t3_result", 64'({o_ovf[0], o_cout[0], o_sum[0]}),
                        64'(bp_exp[(t < 5) ? 0 : t - 5]));
            $display("t3 cycle %0d: out_ready=%0b sum=0x%0h", t, out_ready, o_sum[0]);
         end
         if (in_valid && o_ready[0]) acc++;
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_value("t3_empty", 64'(o_valid[0]), 64'd0);
      step();

      // Asynchronous reset with two beats in flight.
      sel = 0; out_ready = 1'b0; in_valid = 1'b1; a = 32'hC0; b = 32'h80; cin = 1'b0; sub_op = 1'b0;
      @(negedge clk);
      step();
      a = 32'h12; b = 32'h34;
      @(negedge clk);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check_value("t4_pre_valid", 64'(o_valid[0]), 64'd1);
      check_value("t4_pre_result", 64'({o_ovf[0], o_cout[0], o_sum[0]}), 64'({2'b11, 32'h40}));
      #2;
      rst = 1'b1;
      #1;
      check_value("t4_rst_valid", 64'(o_valid[0]), 64'd0);
      check_value("t4_rst_outputs", 64'({o_ovf[0], o_cout[0], o_sum[0]}), 64'd0);
      $display("t4 reset asserted mid-flight: out_valid=%0b sum=0x%0h", o_valid[0], o_sum[0]);
      step();
      step();
      rst = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         check_value("t4_no_stale", 64'(o_valid[0]), 64'd0);
         check_value("t4_in_ready", 64'(o_ready[0]), 64'd1);
         step();
      end
      run_one("t4_after_reset", 0, 32'h03, 32'h04, 1'b0, 1'b0, {2'b00, 32'h07}, 2);

      run_one("t6_full_carry", 2, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {2'b01, 32'h0}, 4);
      run_one("t6_zero_minus_1", 2, 32'h0, 32'h1, 1'b0, 1'b1, {2'b00, 32'hFFFF_FFFF}, 4);

      run_one("cfg13_latency", 1, 32'h1FFF, 32'h1, 1'b0, 1'b0, model(32'h1FFF, 32'h1, 1'b0, 1'b0, 13), 4);
      run_one("cfg8_8_latency", 3, 32'h7F, 32'h1, 1'b0, 1'b0, model(32'h7F, 32'h1, 1'b0, 1'b0, 8), 1);

      run_random(1, 13, 2000);
      run_random(2, 32, 2000);
      run_random(3, 8, 2000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
